// File: rtl/l1_line_fill_ctrl.sv
// Bus-side L1 controller: runs line fills, single uncached reads and
// write-throughs as req/ack system-bus transactions.
`timescale 1ns/1ps
module l1_line_fill_ctrl #(
    parameter int unsigned LINE_BYTES = 2048,
    parameter int unsigned OFF_W      = 11,
    parameter int unsigned BEAT_BYTES = 8,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             read_line_req,
    input  logic             read_req,
    input  logic             write_through_req,
    input  logic [3:0]       L1_size,
    input  logic [63:0]      pa,
    input  logic [63:0]      wt_data,
    output logic [63:0]      line_data,
    output logic [OFF_W-1:0] addr_count,
    output logic             line_write,
    output logic             cache_entry_write,
    output logic             trans_rdy,
    output logic             bus_error,
    output logic             bus_req,
    output logic             bus_we,
    output logic [63:0]      bus_addr,
    output logic [3:0]       bus_size,
    output logic [63:0]      bus_wdata,
    input  logic [63:0]      bus_rdata,
    input  logic             bus_ack,
    input  logic             bus_err
);
    localparam int unsigned BEAT_SH   = $clog2(BEAT_BYTES);
    localparam int unsigned BEAT_W    = OFF_W - BEAT_SH;
    localparam int unsigned NUM_BEATS = LINE_BYTES / BEAT_BYTES;
    localparam int unsigned TO_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        IDLE, LINE, SINGLE_RD, SINGLE_WR, DONE, FAULT
    } state_t;

    state_t            state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [63:0]       line_data_q, line_data_d;
    logic [OFF_W-1:0]  addr_count_q, addr_count_d;
    logic              line_write_q, line_write_d;
    logic              cache_entry_write_q, cache_entry_write_d;
    logic              trans_rdy_q, trans_rdy_d;
    logic              bus_error_q, bus_error_d;

    logic busy;
    logic timed_out;
    logic beat_fail;
    logic beat_ok;
    logic last_beat;

    assign busy      = (state_q == LINE) || (state_q == SINGLE_RD) || (state_q == SINGLE_WR);
    assign timed_out = (TIMEOUT != 0) && (to_cnt_q == TO_W'(TIMEOUT));
    // bus_err (and timeout) win over a simultaneous ack
    assign beat_fail = busy && (bus_err || timed_out);
    assign beat_ok   = busy && bus_ack && !beat_fail;
    assign last_beat = (beat_q == BEAT_W'(NUM_BEATS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q             <= IDLE;
            beat_q              <= '0;
            to_cnt_q            <= '0;
            line_data_q         <= '0;
            addr_count_q        <= '0;
            line_write_q        <= 1'b0;
            cache_entry_write_q <= 1'b0;
            trans_rdy_q         <= 1'b0;
            bus_error_q         <= 1'b0;
        end else begin
            state_q             <= state_d;
            beat_q              <= beat_d;
            to_cnt_q            <= to_cnt_d;
            line_data_q         <= line_data_d;
            addr_count_q        <= addr_count_d;
            line_write_q        <= line_write_d;
            cache_entry_write_q <= cache_entry_write_d;
            trans_rdy_q         <= trans_rdy_d;
            bus_error_q         <= bus_error_d;
        end
    end

    always_comb begin
        state_d             = state_q;
        beat_d              = beat_q;
        to_cnt_d            = '0;
        line_data_d         = line_data_q;
        addr_count_d        = addr_count_q;
        line_write_d        = 1'b0;
        cache_entry_write_d = 1'b0;
        trans_rdy_d         = 1'b0;
        bus_error_d         = 1'b0;

        if (busy && !beat_ok) begin
            to_cnt_d = (to_cnt_q == '1) ? to_cnt_q : to_cnt_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                beat_d = '0;
                if (read_line_req) begin
                    state_d = LINE;
                end else if (read_req) begin
                    state_d = SINGLE_RD;
                end else if (write_through_req) begin
                    state_d = SINGLE_WR;
                end
            end
            LINE: begin
                if (beat_fail) begin
                    state_d     = FAULT;
                    bus_error_d = 1'b1;
                end else if (beat_ok) begin
                    line_data_d  = bus_rdata;
                    addr_count_d = {beat_q, {BEAT_SH{1'b0}}};
                    line_write_d = 1'b1;
                    beat_d       = beat_q + 1'b1;
                    if (last_beat) begin
                        state_d             = DONE;
                        trans_rdy_d         = 1'b1;
                        cache_entry_write_d = 1'b1;
                    end
                end
            end
            SINGLE_RD: begin
                if (beat_fail) begin
                    state_d     = FAULT;
                    bus_error_d = 1'b1;
                end else if (beat_ok) begin
                    state_d     = DONE;
                    line_data_d = bus_rdata;
                    trans_rdy_d = 1'b1;
                end
            end
            SINGLE_WR: begin
                if (beat_fail) begin
                    state_d     = FAULT;
                    bus_error_d = 1'b1;
                end else if (beat_ok) begin
                    state_d     = DONE;
                    trans_rdy_d = 1'b1;
                end
            end
            DONE, FAULT: state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    assign bus_req   = busy;
    assign bus_we    = (state_q == SINGLE_WR);
    assign bus_addr  = (state_q == LINE) ? {pa[63:OFF_W], beat_q, {BEAT_SH{1'b0}}} :
                       busy              ? pa : '0;
    assign bus_size  = (state_q == LINE) ? 4'b1000 : busy ? L1_size : '0;
    assign bus_wdata = (state_q == SINGLE_WR) ? wt_data : '0;

    assign line_data         = line_data_q;
    assign addr_count        = addr_count_q;
    assign line_write        = line_write_q;
    assign cache_entry_write = cache_entry_write_q;
    assign trans_rdy         = trans_rdy_q;
    assign bus_error         = bus_error_q;
endmodule

// File: tb/tb_l1_line_fill_ctrl.sv
// Self-checking bench for l1_line_fill_ctrl: directed vector table, directed
// corner sequences and randomized transactions against a transaction model.
`timescale 1ns/1ps
module tb_l1_line_fill_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        read_line_req, read_req, write_through_req;
    logic [3:0]  L1_size;
    logic [63:0] pa, wt_data;
    logic [63:0] line_data;
    logic [10:0] addr_count;
    logic        line_write, cache_entry_write, trans_rdy, bus_error;
    logic        bus_req, bus_we;
    logic [63:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_size;
    logic        bus_ack, bus_err;

    int errors = 0;
    int checks = 0;

    l1_line_fill_ctrl #(.LINE_BYTES(2048), .OFF_W(11), .BEAT_BYTES(8), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst),
        .read_line_req(read_line_req), .read_req(read_req),
        .write_through_req(write_through_req), .L1_size(L1_size),
        .pa(pa), .wt_data(wt_data),
        .line_data(line_data), .addr_count(addr_count), .line_write(line_write),
        .cache_entry_write(cache_entry_write), .trans_rdy(trans_rdy),
        .bus_error(bus_error), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_size(bus_size), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1);
    end

    typedef struct {
        int unsigned kind;   // 0 line, 1 read, 2 write
        logic [63:0] pa;
        logic [3:0]  size;
        logic [63:0] wdata;
        logic [63:0] rdata;
        int unsigned delay;
        bit          err;
        logic [63:0] e_addr;
        logic [3:0]  e_size;
        logic        e_we;
        logic [63:0] e_wdata;
        logic [63:0] e_ldata;
        logic        e_rdy;
        logic        e_berr;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int unsigned k);
        read_line_req     = (k == 0);
        read_req          = (k == 1);
        write_through_req = (k == 2);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"},   bus_req, 0);
        chk({tag, "_we"},    bus_we, 0);
        chk({tag, "_addr"},  bus_addr, 0);
        chk({tag, "_size"},  bus_size, 0);
        chk({tag, "_wdata"}, bus_wdata, 0);
        chk({tag, "_ldata"}, line_data, 0);
        chk({tag, "_acnt"},  addr_count, 0);
        chk({tag, "_lw"},    line_write, 0);
        chk({tag, "_cew"},   cache_entry_write, 0);
        chk({tag, "_rdy"},   trans_rdy, 0);
        chk({tag, "_berr"},  bus_error, 0);
    endtask

    task automatic apply_vec(input vec_t v);
        pa = v.pa; L1_size = v.size; wt_data = v.wdata;
        set_req(v.kind);
        tick();
        set_req(3);
        repeat (v.delay) begin
            chk("vec_wait_req", bus_req, 1);
            tick();
            chk("vec_wait_rdy", trans_rdy, 0);
        end
        chk("vec_addr", bus_addr, v.e_addr);
        chk("vec_size", bus_size, v.e_size);
        chk("vec_we", bus_we, v.e_we);
        if (v.e_we) chk("vec_wdata", bus_wdata, v.e_wdata);
        bus_rdata = v.rdata;
        if (v.err) bus_err = 1'b1; else bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0; bus_err = 1'b0;
        chk("vec_rdy", trans_rdy, v.e_rdy);
        chk("vec_berr", bus_error, v.e_berr);
        chk("vec_lw", line_write, 0);
        chk("vec_cew", cache_entry_write, 0);
        chk("vec_req_off", bus_req, 0);
        chk("vec_ldata", line_data, v.e_ldata);
        tick();
        chk("vec_idle_req", bus_req, 0);
        chk("vec_idle_rdy", trans_rdy, 0);
    endtask

    // Transaction model: expected bus addresses, beat offsets and pulses
    // are derived from the request alone.
    task automatic run_txn(input int unsigned kind, input logic [63:0] pa_i,
                           input logic [3:0] sz, input logic [63:0] wd,
                           input int err_beat, input int unsigned max_delay,
                           output int n_lw);
        logic [63:0] rd, exp_addr;
        int nb;
        bit last;
        nb = (kind == 0) ? 256 : 1;
        n_lw = 0;
        pa = pa_i; L1_size = sz; wt_data = wd;
        set_req(kind);
        tick();
        set_req(3);
        for (int b = 0; b < nb; b++) begin
            repeat ($urandom_range(max_delay, 0)) begin
                chk("wait_req", bus_req, 1);
                tick();
                if (line_write) n_lw++;
                chk("wait_lw", line_write, 0);
                chk("wait_rdy", trans_rdy, 0);
            end
            exp_addr = (kind == 0) ? ((pa_i & ~64'h7FF) + 64'(b) * 8) : pa_i;
            chk("req", bus_req, 1);
            chk("addr", bus_addr, exp_addr);
            chk("size", bus_size, (kind == 0) ? 4'b1000 : sz);
            chk("we", bus_we, kind == 2);
            if (kind == 2) chk("wdata", bus_wdata, wd);
            rd = {$urandom, $urandom};
            bus_rdata = rd;
            if (b == err_beat) begin
                bus_err = 1'b1;
                bus_ack = 1'($urandom_range(1, 0));
            end else begin
                bus_ack = 1'b1;
            end
            tick();
            bus_ack = 1'b0; bus_err = 1'b0;
            if (line_write) n_lw++;
            if (b == err_beat) begin
                chk("err_pulse", bus_error, 1);
                chk("err_req", bus_req, 0);
                chk("err_lw", line_write, 0);
                chk("err_rdy", trans_rdy, 0);
                chk("err_cew", cache_entry_write, 0);
                break;
            end
            last = (b == nb - 1);
            chk("lw", line_write, kind == 0);
            chk("rdy", trans_rdy, last);
            chk("cew", cache_entry_write, last && kind == 0);
            chk("berr", bus_error, 0);
            if (kind == 0) chk("acnt", addr_count, 64'(b) * 8);
            if (kind != 2) chk("ldata", line_data, rd);
            if (last) chk("done_req", bus_req, 0);
        end
        tick();
        chk("idle_req", bus_req, 0);
        chk("idle_rdy", trans_rdy, 0);
        chk("idle_berr", bus_error, 0);
        chk("idle_lw", line_write, 0);
    endtask

    initial begin
        int n_lw;
        int cyc;
        int unsigned kind;
        int eb;

        vecs[0] = '{1, 64'h1004, 4'b0100, 64'h0, 64'hDEAD_BEEF, 3, 1'b0,
                    64'h1004, 4'b0100, 1'b0, 64'h0, 64'hDEAD_BEEF, 1'b1, 1'b0};
        vecs[1] = '{2, 64'h2008, 4'b0001, 64'h55, 64'h0, 0, 1'b0,
                    64'h2008, 4'b0001, 1'b1, 64'h55, 64'hDEAD_BEEF, 1'b1, 1'b0};
        vecs[2] = '{1, 64'hFFFF_0000_0000_0007, 4'b0001, 64'h0, 64'h1234, 1, 1'b1,
                    64'hFFFF_0000_0000_0007, 4'b0001, 1'b0, 64'h0, 64'hDEAD_BEEF, 1'b0, 1'b1};
        vecs[3] = '{2, 64'h10, 4'b1000, 64'h0123_4567_89AB_CDEF, 64'h0, 2, 1'b1,
                    64'h10, 4'b1000, 1'b1, 64'h0123_4567_89AB_CDEF, 64'hDEAD_BEEF, 1'b0, 1'b1};
        vecs[4] = '{1, 64'h3002, 4'b0010, 64'h0, 64'hCAFE, 0, 1'b0,
                    64'h3002, 4'b0010, 1'b0, 64'h0, 64'hCAFE, 1'b1, 1'b0};

        rst = 1'b1;
        set_req(3);
        L1_size = 4'b0001; pa = 64'h1234_5678_9ABC_DEF0; wt_data = '1;
        bus_rdata = '0; bus_ack = 1'b0; bus_err = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        foreach (vecs[i]) apply_vec(vecs[i]);

        // T1: full line fill, ack every cycle
        run_txn(0, 64'h8000_1234, 4'b0001, 64'h0, -1, 0, n_lw);
        chk("t1_lw_count", n_lw, 256);

        // T4: error on beat 10
        run_txn(0, 64'h0000_0000_0003_0000, 4'b0001, 64'h0, 10, 1, n_lw);
        chk("t4_lw_count", n_lw, 10);

        // Request held through the DONE cycle must not restart a transaction
        pa = 64'h2008; L1_size = 4'b0001; wt_data = 64'h55;
        set_req(2);
        tick();
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        chk("hold_rdy", trans_rdy, 1);
        tick();
        chk("hold_done_ignored", bus_req, 0);
        set_req(3);
        tick();
        chk("hold_idle", bus_req, 0);

        // Priority: read beats write-through
        pa = 64'h4000; L1_size = 4'b0010;
        read_req = 1'b1; write_through_req = 1'b1;
        tick();
        set_req(3);
        chk("prio_rd_we", bus_we, 0);
        chk("prio_rd_size", bus_size, 4'b0010);
        bus_ack = 1'b1; bus_rdata = 64'h77;
        tick();
        bus_ack = 1'b0;
        chk("prio_rd_ldata", line_data, 64'h77);
        tick();

        // Priority: line fill beats read (aborted by reset)
        read_line_req = 1'b1; read_req = 1'b1;
        tick();
        set_req(3);
        chk("prio_line_size", bus_size, 4'b1000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("prio_abort_req", bus_req, 0);

        for (int t = 0; t < 20; t++) begin
            kind = $urandom_range(2, 0);
            eb = ($urandom_range(3, 0) == 0) ? int'($urandom_range((kind == 0) ? 255 : 0, 0)) : -1;
            run_txn(kind, {$urandom, $urandom}, 4'b0001 << $urandom_range(3, 0),
                    {$urandom, $urandom}, eb, 3, n_lw);
        end

        // T5: no ack -> timeout fault
        pa = 64'h40; L1_size = 4'b1000;
        set_req(1);
        tick();
        set_req(3);
        chk("t5_req_up", bus_req, 1);
        cyc = 0;
        while (!bus_error && cyc < 400) begin
            tick();
            cyc++;
        end
        chk("t5_timeout_cycles", cyc, 256);
        chk("t5_req_off", bus_req, 0);
        chk("t5_rdy", trans_rdy, 0);
        tick();

        // T6: reset at line beat 100
        pa = 64'h4000_0ABC;
        set_req(0);
        tick();
        set_req(3);
        bus_ack = 1'b1; bus_rdata = 64'h1111;
        repeat (100) tick();
        bus_ack = 1'b0;
        chk("t6_beat100_addr", bus_addr, 64'h4000_0B20);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_all_zero("t6");
        apply_vec(vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
